// File: rtl/dac_feeder_pkg.sv
// Shared constants and types for the DAC sample feeder: DAC code width,
// the code typedef and the default FIFO depth / rate divider width.
package dac_feeder_pkg;

    localparam int DAC_W     = 10;
    localparam int DEPTH_DEF = 8;
    localparam int DIV_W_DEF = 16;

    typedef logic [DAC_W-1:0] dac_code_t;

endpackage

// File: rtl/dac_feeder_fifo.sv
// Sample FIFO for the DAC feeder. Pointers carry one extra wrap bit so equal
// indices can be told apart as full or empty. DEPTH must be a power of two >= 2.
module dac_feeder_fifo
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
)
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  dac_code_t push_data,
    input  logic      pop,
    output dac_code_t pop_data,
    output logic      empty,
    output logic      full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    dac_code_t        mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);

    // Guard here too so the FIFO stays consistent even if a caller ignores status.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign pop_data = mem_q[rptr_q[IDX_W-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Paces samples from the core into the DAC D register at a programmable rate.
// Define DAC_FEEDER_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module dac_sample_feeder
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DIV_W = DIV_W_DEF
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] rate_div,
    input  logic [DAC_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DAC_W-1:0] D,
    output logic             sample_strobe,
    output logic             empty,
    output logic             full,
    output logic             underrun
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]      underrun_cnt
`endif
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    dac_code_t        d_q, d_d;
    dac_code_t        fifo_data;
    logic             strobe_q;
    logic             underrun_q, underrun_d;
    logic             fifo_empty, fifo_full;
    logic             tick;
    logic             push;
    logic             pop;

    dac_feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Comparing with >= lets a lowered rate_div take effect immediately.
    assign tick       = en && (cnt_q >= rate_div);
    assign pop        = tick && !fifo_empty;
    assign underrun_d = tick && fifo_empty;

    // Held low while reset is asserted, ready again on the first cycle after release.
    assign in_ready = !fifo_full && !reset;
    assign push     = in_valid && in_ready;

    always_comb begin
        cnt_d = cnt_q;
        d_d   = d_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        if (pop) begin
            d_d = fifo_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            d_q        <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            d_q        <= d_d;
            strobe_q   <= pop;
            underrun_q <= underrun_d;
        end
    end

    assign D             = d_q;
    assign sample_strobe = strobe_q;
    assign underrun      = underrun_q;
    assign empty         = fifo_empty;
    assign full          = fifo_full;

`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Counts alongside the pulse register so the count includes the visible pulse.
    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Bench for dac_sample_feeder: directed scenarios plus a randomized run, all
// compared each cycle against a queue-based reference model of the feeder.
module tb_dac_sample_feeder;
    import dac_feeder_pkg::*;

    localparam int DEPTH = 8;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [DIV_W-1:0] rate_div;
    logic [9:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       D;
    logic             sample_strobe;
    logic             empty;
    logic             full;
    logic             underrun;
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    logic [15:0]      underrun_cnt;
`endif

    dac_sample_feeder #(
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .rate_div      (rate_div),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .D             (D),
        .sample_strobe (sample_strobe),
        .empty         (empty),
        .full          (full),
        .underrun      (underrun)
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt  (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model state
    logic [9:0] mq[$];
    int         m_cnt;
    logic [9:0] m_d;
    logic       m_strobe;
    logic       m_under;
    int         m_ucnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: model advances from current inputs, then DUT outputs are compared.
    task automatic cycle();
        bit was_empty, tick, push, pop, ready;
        was_empty = (mq.size() == 0);
        ready     = (mq.size() != DEPTH) && !reset;
        tick      = en && (m_cnt >= int'(rate_div));
        push      = in_valid && ready;
        pop       = tick && !was_empty;
        m_strobe  = pop;
        m_under   = tick && was_empty;
        if (pop) m_d = mq.pop_front();
        if (push) mq.push_back(in_data);
        if (!en || tick) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        if (m_under && m_ucnt != 65535) m_ucnt = m_ucnt + 1;
        @(posedge clk);
        #1;
        check("D", D, m_d);
        check("sample_strobe", sample_strobe, m_strobe);
        check("underrun", underrun, m_under);
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() == DEPTH);
        check("in_ready", in_ready, mq.size() != DEPTH);
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, m_ucnt);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mq.delete();
        m_cnt = 0; m_d = '0; m_strobe = 0; m_under = 0; m_ucnt = 0;
        #1;
        check("rst_D", D, 10'h000);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_strobe", sample_strobe, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        int n_str, n_und, last, k;
        bit got;
        logic [9:0] pushed [9];
        logic [9:0] r;

        en = 0; rate_div = '0; in_data = '0; in_valid = 0;
        do_reset();

        // Back-to-back 3FA..3FF at rate_div=4
        en = 1; rate_div = 4;
        n_str = 0; n_und = 0; last = -1;
        for (int c = 0; c < 60 && n_str < 6; c++) begin
            in_valid = (c < 6);
            in_data  = 10'(10'h3FA + c);
            cycle();
            if (underrun) n_und++;
            if (sample_strobe) begin
                check("s30_D", D, 10'h3FA + n_str);
                if (last >= 0) check("s30_gap", c - last, 5);
                last = c;
                n_str++;
            end
        end
        check("s30_strobes", n_str, 6);
        check("s30_no_underrun", n_und, 0);
        en = 0; in_valid = 0;

        // Fill to full with en=0; 9th held until playback pops
        do_reset();
        rate_div = 0;
        for (int i = 0; i < 9; i++) pushed[i] = 10'($urandom);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = pushed[i];
            cycle();
        end
        check("s31_full", full, 1'b1);
        check("s31_ready_low", in_ready, 1'b0);
        in_data = pushed[8];
        repeat (3) cycle();
        check("s31_still_full", full, 1'b1);
        en = 1; got = 0; k = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (in_ready) got = 1;
            cycle();
            if (sample_strobe) begin
                check("s31_D", D, pushed[k]);
                k++;
            end
        end
        check("s31_ninth_accepted", got, 1'b1);
        in_valid = 0;
        for (int c = 0; c < 20 && k < 9; c++) begin
            cycle();
            if (sample_strobe) begin
                check("s31_D", D, pushed[k]);
                k++;
            end
        end
        check("s31_drained", k, 9);

        // Empty FIFO at rate_div=0: underrun every cycle, D holds
        repeat (5) begin
            cycle();
            check("s32_underrun", underrun, 1'b1);
            check("s32_D_hold", D, pushed[8]);
        end

        // Push on empty coincident with a tick
        en = 0;
        cycle();
        en = 1; rate_div = 3;
        for (int c = 0; c < 10 && m_cnt != 3; c++) cycle();
        r = 10'($urandom) | 10'h001;
        in_valid = 1; in_data = r;
        cycle();
        check("s33_underrun", underrun, 1'b1);
        check("s33_no_strobe", sample_strobe, 1'b0);
        check("s33_not_empty", empty, 1'b0);
        in_valid = 0; got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            cycle();
            if (sample_strobe) got = 1;
        end
        check("s33_popped", got, 1'b1);
        check("s33_D", D, r);

        // Reset with 5 queued samples, nothing stale afterwards
        en = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = 10'($urandom);
            cycle();
        end
        in_valid = 0;
        do_reset();
        en = 1; rate_div = 1; n_str = 0;
        repeat (8) begin
            cycle();
            if (sample_strobe) n_str++;
        end
        check("s34_no_stale", n_str, 0);

        // rate_div 9 -> 2 with cnt=6
        rate_div = 9;
        for (int c = 0; c < 20 && m_cnt != 6; c++) cycle();
        rate_div = 2;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("s35_tick", underrun, (i % 3) == 0);
        end

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) rate_div = DIV_W'($urandom_range(0, 4));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 10'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dac_sample_feeder.md
DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO depth in samples (power of two, minimum 2).
REQ-002 SHALL have parameter DIV_W, default 16, meaning the width of rate_div.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, playback enable.
REQ-006 SHALL have port rate_div, input, DIV_W, sample period minus one, in clk cycles.
REQ-007 SHALL have port in_data, input, 10, sample from the core.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, FIFO can accept a sample.
REQ-010 SHALL have port D, output, 10, registered code to avsddac D.
REQ-011 SHALL have port sample_strobe, output, 1, one-cycle pulse when D updates.
REQ-012 SHALL have ports empty and full, output, 1 each, FIFO status.
REQ-013 SHALL have port underrun, output, 1, one-cycle pulse on a tick with the FIFO empty.

Function
REQ-014 SHALL push in_data when in_valid && in_ready; in_ready = !full, driven from registered state.
REQ-015 SHALL run tick counter cnt only while en=1; tick when cnt >= rate_div, then cnt <= 0; otherwise cnt <= cnt+1.
REQ-016 SHALL hold cnt at 0 while en=0; no ticks, no pops, D holds; pushes still accepted.
REQ-017 SHALL tick every cycle when rate_div=0.
REQ-018 SHALL, on a tick with FIFO non-empty, pop the oldest sample into D and assert sample_strobe on the following cycle (1-cycle latency, D and strobe change together).
REQ-019 SHALL, on a tick with FIFO empty, hold D, assert underrun for one cycle, and leave sample_strobe low.
REQ-020 SHALL not make a sample pushed in cycle N poppable before cycle N+1; push and tick on empty in the same cycle is an underrun.
REQ-021 SHALL allow simultaneous push and pop when neither full nor empty; occupancy unchanged.
REQ-022 SHALL wrap read/write pointers modulo DEPTH, with a wrap bit distinguishing full from empty.
REQ-023 SHALL let a rate_div change take effect from the next comparison; no reset of cnt is required.

Reset
REQ-024 SHALL, on reset, asynchronously set D=10'h000, sample_strobe=0, underrun=0, empty=1, full=0, in_ready=0 while reset is asserted, cnt=0, and clear both pointers.
REQ-025 SHALL discard FIFO contents on reset asserted mid-operation; in_ready=1 on the first cycle after release.

Configuration
REQ-026 SHALL, with DAC_FEEDER_UNDERRUN_CNT_EN defined, add output underrun_cnt[15:0], incremented per underrun pulse, saturating at 16'hFFFF and cleared by reset.
REQ-027 SHALL, without DAC_FEEDER_UNDERRUN_CNT_EN, have neither the port nor the counter; all other behaviour is identical.

Structure
REQ-028 SHALL take DAC_W=10, the dac_code_t typedef (10-bit), and DEPTH/DIV_W defaults from shared package dac_feeder_pkg.
REQ-029 SHALL implement the FIFO as sub-module dac_feeder_fifo (push/pop/data/empty/full); tick counter and output register live in the top.

Verification
REQ-030 SHALL verify: reset, then push 10'h3FA..10'h3FF back-to-back with en=1, rate_div=4 -> D steps 3FA..3FF every 5 cycles, one strobe each, no underrun.
REQ-031 SHALL verify: DEPTH=8 with en=0, push 9 samples -> in_ready low after the 8th, full=1, 9th held until en=1 and first pop.
REQ-032 SHALL verify: en=1, rate_div=0, FIFO empty -> underrun every cycle, D holds last value; with the macro, underrun_cnt counts up.
REQ-033 SHALL verify: push on empty coincident with tick -> underrun that cycle; sample appears on D at the next tick.
REQ-034 SHALL verify: reset asserted with 5 samples queued -> D=000, empty=1 immediately; after release no stale sample is output.
REQ-035 SHALL verify: rate_div changed from 9 to 2 with cnt=6 -> tick on the next cycle, then every 3 cycles.
